// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: core-side MEM_* request/response handshake bundle
//   exec/write/size/addr/data_out : request from core (master -> slave)
//   ready/data_in/data_ready      : status and read data back to core (slave -> master)
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              exec;
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic [DATA_W-1:0] data_in;
    logic              data_ready;
    modport master (output exec, write, size, addr, data_out, input ready, data_in, data_ready);
    modport slave  (input exec, write, size, addr, data_out, output ready, data_in, data_ready);
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: core memory/IO controller routing accesses to boot ROM, RAM or UART MMIO
//   i_clk, i_reset           : clock, synchronous active-high reset
//   mem (slave modport)      : core request/response handshake
//   o_ram_* / i_ram_data_out : RAM strobe, direction, size, address, write data, read data
//   o_rom_* / i_rom_data     : boot ROM strobe, byte address, read data
//   i_uart_rx_*              : received byte, buffered in an RX FIFO
//   i_uart_tx_ready, o_uart_tx_* : transmitter handshake
//   o_booting                : boot ROM overlay still active
//   Optional macro MEMBUS_TIMEOUT_EN: abort a TX write stalled for TIMEOUT cycles.
module mem_bus_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BOOT_SIZE = 'h64,
    parameter int MMIO_BASE = 'h400,
    parameter int RX_DEPTH  = 4,
    parameter int RAM_LAT   = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_bus_ctrl_if.slave     mem,
    output logic              o_ram_enable,
    output logic              o_ram_write,
    output logic [1:0]        o_ram_size,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data_in,
    input  logic [DATA_W-1:0] i_ram_data_out,
    output logic              o_rom_enable,
    output logic [7:0]        o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    input  logic              i_uart_rx_valid,
    input  logic [7:0]        i_uart_rx_byte,
    input  logic              i_uart_tx_ready,
    output logic              o_uart_tx_exec,
    output logic [7:0]        o_uart_tx_byte,
    output logic              o_booting
);
    localparam int PW    = $clog2(RX_DEPTH);
    localparam int CNT_W = $clog2((TIMEOUT > RAM_LAT ? TIMEOUT : RAM_LAT) + 1);
    typedef enum logic [2:0] {IDLE, MMIO_ACK, TX_WAIT, MEM_WAIT, MEM_DONE} state_t;
    state_t            r_state, w_next;
    logic              r_wr, r_rom, r_booting, r_ram_en, r_rom_en;
    logic              r_overrun, r_tx_err, r_tx_exec, r_data_ready;
    logic [1:0]        r_size, r_off;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_data_in;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_fifo [RX_DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [PW:0]       r_count;
    logic              w_accept, w_mmio, w_rom, w_done, w_pop, w_push, w_tx_go, w_abort;
    logic              w_empty, w_full, w_ovr_set, w_ovr_clr, w_err_clr;
    logic [ADDR_W-1:0] w_off;
    logic [DATA_W-1:0] w_mmio_rd;
    assign w_accept = r_state == IDLE && mem.exec;
    assign w_off    = mem.addr - ADDR_W'(MMIO_BASE);
    assign w_mmio   = mem.addr >= ADDR_W'(MMIO_BASE) && w_off < ADDR_W'(4);
    assign w_rom    = !mem.write && r_booting && mem.addr < ADDR_W'(BOOT_SIZE);
    assign w_empty  = r_count == '0;
    assign w_full   = r_count == (PW+1)'(RX_DEPTH);
    // a full FIFO still accepts a byte when the head is popped in the same cycle
    assign w_push    = i_uart_rx_valid && (!w_full || w_pop);
    assign w_ovr_set = i_uart_rx_valid && w_full && !w_pop;
    assign w_ovr_clr = r_state == MMIO_ACK && !r_wr && r_off == 2'd1;
    assign w_err_clr = r_state == MMIO_ACK && !r_wr && r_off == 2'd2;
    assign w_mmio_rd = r_off == 2'd0 ? (w_empty ? '0 : DATA_W'(r_fifo[r_rp])) :
                       r_off == 2'd1 ? DATA_W'({r_count, r_overrun, !w_empty}) :
                       r_off == 2'd2 ? DATA_W'({r_tx_err, i_uart_tx_ready}) : DATA_W'(r_booting);
    always_ff @(posedge i_clk)
        r_state <= i_reset ? IDLE : w_next;
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_pop   = 1'b0;
        w_tx_go = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE:     if (mem.exec) w_next = w_mmio ? ((mem.write && w_off[1:0] == 2'd0) ? TX_WAIT : MMIO_ACK) : MEM_WAIT;
            MMIO_ACK: begin
                w_next = IDLE;
                w_done = 1'b1;
                w_pop  = !r_wr && r_off == 2'd0 && !w_empty;
            end
            TX_WAIT:  begin
                w_tx_go = i_uart_tx_ready;
`ifdef MEMBUS_TIMEOUT_EN
                w_abort = !i_uart_tx_ready && r_cnt == CNT_W'(TIMEOUT - 1);
`endif
                w_done  = w_tx_go || w_abort;
                w_next  = w_done ? IDLE : TX_WAIT;
            end
            MEM_WAIT: if (r_cnt == '0) w_next = MEM_DONE;
            MEM_DONE: begin
                w_next = IDLE;
                w_done = 1'b1;
            end
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk)
        if (w_push) r_fifo[r_wp] <= i_uart_rx_byte;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr         <= 1'b0;
            r_rom        <= 1'b0;
            r_booting    <= 1'b1;
            r_ram_en     <= 1'b0;
            r_rom_en     <= 1'b0;
            r_overrun    <= 1'b0;
            r_tx_err     <= 1'b0;
            r_tx_exec    <= 1'b0;
            r_data_ready <= 1'b0;
            r_size       <= '0;
            r_off        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_data_in    <= '0;
            r_cnt        <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
        end else begin
            r_ram_en     <= w_accept && !w_mmio && !w_rom;
            r_rom_en     <= w_accept && !w_mmio && w_rom;
            r_data_ready <= w_done;
            r_tx_exec    <= w_tx_go;
            if (w_accept) begin
                r_wr    <= mem.write;
                r_addr  <= mem.addr;
                r_size  <= mem.size;
                r_wdata <= mem.data_out;
                r_off   <= w_off[1:0];
                r_rom   <= w_rom && !w_mmio;
                // MEM_WAIT counts down from RAM_LAT-1; TX_WAIT counts up from 0
                r_cnt   <= w_mmio ? '0 : CNT_W'(RAM_LAT - 1);
                if (!mem.write && !w_mmio && mem.addr >= ADDR_W'(BOOT_SIZE)) r_booting <= 1'b0;
            end else if (r_state == MEM_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (r_state == TX_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == MMIO_ACK && !r_wr) r_data_in <= w_mmio_rd;
            if (r_state == MEM_DONE && !r_wr) r_data_in <= r_rom ? i_rom_data : i_ram_data_out;
            // a new overrun wins over a clearing status read in the same cycle
            r_overrun <= w_ovr_set || (r_overrun && !w_ovr_clr);
            r_tx_err  <= w_abort || (r_tx_err && !w_err_clr);
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
    assign mem.ready      = r_state == IDLE;
    assign mem.data_in    = r_data_in;
    assign mem.data_ready = r_data_ready;
    assign o_ram_enable   = r_ram_en;
    assign o_ram_write    = r_wr;
    assign o_ram_size     = r_size;
    assign o_ram_addr     = r_addr;
    assign o_ram_data_in  = r_wdata;
    assign o_rom_enable   = r_rom_en;
    assign o_rom_addr     = r_addr[7:0];
    assign o_uart_tx_exec = r_tx_exec;
    assign o_uart_tx_byte = r_wdata[7:0];
    assign o_booting      = r_booting;
endmodule
